// File: rtl/pipe_pkg.sv
// Shared types for the ID-stage hazard/sequencing controller.
//   state_t : sequencer states (RUN, DRAIN, ISSUE, RELEASE)
//   slot_t  : one in-flight destination tracker entry {v, dst, load}
//   REG_ZERO: register $0, which never creates a dependency
//   src_hit : one source operand against one slot
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      ISSUE   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   typedef struct packed {
      logic       v;
      logic [4:0] dst;
      logic       load;
   } slot_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic src_hit(input logic uses, input logic [4:0] r, input slot_t s);
      return uses && s.v && (r != REG_ZERO) && (r == s.dst);
   endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage bundle between the decode stage and the hazard controller.
//   ID_* : description of the instruction currently held in ID
//   FREEZE_IF / BUBBLE_ID / FLUSH_IF : pipeline steering back to IF and ID
//   SYS  : one-cycle syscall strobe to the simulator
//   BUSY : sequencer is outside RUN
// master = decode side (drives ID_*), slave = controller.
interface id_hazard_ctrl_if;
   logic       ID_Valid;
   logic [4:0] ID_RegA;
   logic [4:0] ID_RegB;
   logic       ID_UsesA;
   logic       ID_UsesB;
   logic [4:0] ID_WriteReg;
   logic       ID_RegWrite;
   logic       ID_MemRead;
   logic       ID_Syscall;
   logic       ID_Mispredict;
   logic       FREEZE_IF;
   logic       BUBBLE_ID;
   logic       FLUSH_IF;
   logic       SYS;
   logic       BUSY;

   modport master (
      output ID_Valid, ID_RegA, ID_RegB, ID_UsesA, ID_UsesB, ID_WriteReg,
             ID_RegWrite, ID_MemRead, ID_Syscall, ID_Mispredict,
      input  FREEZE_IF, BUBBLE_ID, FLUSH_IF, SYS, BUSY
   );

   modport slave (
      input  ID_Valid, ID_RegA, ID_RegB, ID_UsesA, ID_UsesB, ID_WriteReg,
             ID_RegWrite, ID_MemRead, ID_Syscall, ID_Mispredict,
      output FREEZE_IF, BUBBLE_ID, FLUSH_IF, SYS, BUSY
   );
endinterface

// File: rtl/hazard_slot_cmp.sv
// Compares one tracker slot against the two ID source registers.
//   slot      : tracked in-flight destination
//   reg_a/b   : ID source registers, uses_a/b say whether each is consumed
//   load_only : only a load in this slot counts (bypass covers the rest)
//   match     : read-after-write dependency on this slot
module hazard_slot_cmp
   import pipe_pkg::*;
(
   input  slot_t      slot,
   input  logic [4:0] reg_a,
   input  logic [4:0] reg_b,
   input  logic       uses_a,
   input  logic       uses_b,
   input  logic       load_only,
   output logic       match
);

   logic hit;

   assign hit   = src_hit(uses_a, reg_a, slot) | src_hit(uses_b, reg_b, slot);
   assign match = hit & (~load_only | slot.load);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard and syscall sequencing controller.
//   CLK, RESET (async, active-low)
//   bus (slave): ID_* instruction description in; FREEZE_IF, BUBBLE_ID and
//   FLUSH_IF combinational out; SYS and BUSY registered out.
// Parameters: HAS_FORWARDING (1: only load-use stalls), DRAIN_CYCLES (1..7).
//
// state   | meaning
// RUN     | normal flow; stall on RAW hazard, start syscall drain, flush on mispredict
// DRAIN   | bubbling ID while older instructions retire, cnt counting down
// ISSUE   | SYS strobe (suppressed for LL/SC), ID still held
// RELEASE | syscall leaves ID once, then back to RUN
module id_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int HAS_FORWARDING = 1,
   parameter int DRAIN_CYCLES   = 3
) (
   input logic             CLK,
   input logic             RESET,
   id_hazard_ctrl_if.slave bus
);

   localparam logic [2:0] DRAIN_LD   = 3'(DRAIN_CYCLES);
   localparam logic       FWD_LOADS  = (HAS_FORWARDING != 0);

   state_t     state;
   logic [2:0] cnt;
   logic       sys_q;
   logic       busy_q;
   slot_t      s0, s1, s2;
   slot_t      s0_nxt;
   logic       m0, m1, m2;
   logic       hazard;
   logic       start_sys;
   logic       freeze_c, bubble_c, flush_c;

   hazard_slot_cmp u_cmp_exe (
      .slot(s0), .reg_a(bus.ID_RegA), .reg_b(bus.ID_RegB),
      .uses_a(bus.ID_UsesA), .uses_b(bus.ID_UsesB),
      .load_only(FWD_LOADS), .match(m0)
   );

   hazard_slot_cmp u_cmp_mem (
      .slot(s1), .reg_a(bus.ID_RegA), .reg_b(bus.ID_RegB),
      .uses_a(bus.ID_UsesA), .uses_b(bus.ID_UsesB),
      .load_only(1'b0), .match(m1)
   );

   hazard_slot_cmp u_cmp_wb (
      .slot(s2), .reg_a(bus.ID_RegA), .reg_b(bus.ID_RegB),
      .uses_a(bus.ID_UsesA), .uses_b(bus.ID_UsesB),
      .load_only(1'b0), .match(m2)
   );

   // With bypass only the EXE-stage load matters; without it, any pending write.
   always_comb begin
      hazard = 1'b0;
      if (FWD_LOADS) hazard = bus.ID_Valid & m0;
      else           hazard = bus.ID_Valid & (m0 | m1 | m2);
   end

   assign start_sys = bus.ID_Valid & bus.ID_Syscall & ~hazard;

   // Steering outputs are forced low while RESET is held so the pipeline
   // sees a clean idle controller regardless of what ID presents.
   always_comb begin
      freeze_c = 1'b0;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
      if (RESET) begin
         case (state)
            RUN: begin
               if (hazard || start_sys) begin
                  freeze_c = 1'b1;
                  bubble_c = 1'b1;
               end else if (bus.ID_Valid && bus.ID_Mispredict) begin
                  flush_c = 1'b1;
               end
            end
            DRAIN, ISSUE: begin
               freeze_c = 1'b1;
               bubble_c = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.FREEZE_IF = freeze_c;
   assign bus.BUBBLE_ID = bubble_c;
   assign bus.FLUSH_IF  = flush_c;
   assign bus.SYS       = sys_q;
   assign bus.BUSY      = busy_q;

   always_comb begin
      s0_nxt = '0;
      if (bus.ID_Valid && bus.ID_RegWrite && (bus.ID_WriteReg != REG_ZERO) && !bubble_c)
         s0_nxt = '{v: 1'b1, dst: bus.ID_WriteReg, load: bus.ID_MemRead};
   end

   // Downstream stages never stall, so the tracker shifts every cycle.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         s0 <= '0;
         s1 <= '0;
         s2 <= '0;
      end else begin
         s0 <= s0_nxt;
         s1 <= s0;
         s2 <= s1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= RUN;
         cnt    <= 3'd0;
         sys_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         sys_q <= 1'b0;
         case (state)
            RUN: begin
               if (start_sys) begin
                  cnt    <= DRAIN_LD;
                  busy_q <= 1'b1;
                  if (DRAIN_CYCLES <= 1) begin
                     state <= ISSUE;
                     sys_q <= ~bus.ID_MemRead;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end
            DRAIN: begin
               // Leave as the count reaches 1: DRAIN_CYCLES-1 drain cycles.
               cnt <= cnt - 3'd1;
               if (cnt <= 3'd2) begin
                  state <= ISSUE;
                  sys_q <= ~bus.ID_MemRead;
               end
            end
            ISSUE: begin
               state <= RELEASE;
               cnt   <= 3'd0;
            end
            RELEASE: begin
               state  <= RUN;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= RUN;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: one instance with bypass, one without, fed the
// same ID stream. Outputs are packed {FREEZE_IF, BUBBLE_ID, FLUSH_IF, SYS, BUSY}.
module tb_id_hazard_ctrl;

   localparam logic [4:0] O_I = 5'b00000;  // idle
   localparam logic [4:0] O_S = 5'b11000;  // stall / syscall detection
   localparam logic [4:0] O_F = 5'b00100;  // fetch flush
   localparam logic [4:0] O_D = 5'b11001;  // drain (and LL issue)
   localparam logic [4:0] O_X = 5'b11011;  // syscall issue
   localparam logic [4:0] O_R = 5'b00001;  // release

   typedef struct {
      logic       v;
      logic [4:0] ra;
      logic       ua;
      logic [4:0] rb;
      logic       ub;
      logic [4:0] wr;
      logic       rw, mr, sc, mp;
      logic [4:0] ef, en;
   } vec_t;

   typedef struct packed {
      logic [4:0] ef;
      logic [4:0] en;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       id_valid, id_usesa, id_usesb, id_regwrite, id_memread, id_syscall, id_mispredict;
   logic [4:0] id_rega, id_regb, id_writereg;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   id_hazard_ctrl_if bus_f ();
   id_hazard_ctrl_if bus_n ();

   assign bus_f.ID_Valid = id_valid;         assign bus_n.ID_Valid = id_valid;
   assign bus_f.ID_RegA = id_rega;           assign bus_n.ID_RegA = id_rega;
   assign bus_f.ID_RegB = id_regb;           assign bus_n.ID_RegB = id_regb;
   assign bus_f.ID_UsesA = id_usesa;         assign bus_n.ID_UsesA = id_usesa;
   assign bus_f.ID_UsesB = id_usesb;         assign bus_n.ID_UsesB = id_usesb;
   assign bus_f.ID_WriteReg = id_writereg;   assign bus_n.ID_WriteReg = id_writereg;
   assign bus_f.ID_RegWrite = id_regwrite;   assign bus_n.ID_RegWrite = id_regwrite;
   assign bus_f.ID_MemRead = id_memread;     assign bus_n.ID_MemRead = id_memread;
   assign bus_f.ID_Syscall = id_syscall;     assign bus_n.ID_Syscall = id_syscall;
   assign bus_f.ID_Mispredict = id_mispredict; assign bus_n.ID_Mispredict = id_mispredict;

   id_hazard_ctrl #(.HAS_FORWARDING(1), .DRAIN_CYCLES(3)) dut_f (
      .CLK(CLK), .RESET(RESET), .bus(bus_f)
   );

   id_hazard_ctrl #(.HAS_FORWARDING(0), .DRAIN_CYCLES(3)) dut_n (
      .CLK(CLK), .RESET(RESET), .bus(bus_n)
   );

   function automatic vec_t mk(input int v, input int ra, input int ua, input int rb, input int ub,
                               input int wr, input int rw, input int mr, input int sc, input int mp,
                               input logic [4:0] ef, input logic [4:0] en);
      vec_t t;
      t.v  = (v != 0);   t.ra = 5'(ra);    t.ua = (ua != 0);
      t.rb = 5'(rb);     t.ub = (ub != 0); t.wr = 5'(wr);
      t.rw = (rw != 0);  t.mr = (mr != 0); t.sc = (sc != 0);
      t.mp = (mp != 0);  t.ef = ef;        t.en = en;
      return t;
   endfunction

   function automatic vec_t idle_v();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_I, O_I);
   endfunction

   function automatic vec_t sys_v(input int mr, input logic [4:0] e);
      return mk(1, 0, 0, 0, 0, 0, 0, mr, 1, 0, e, e);
   endfunction

   task automatic apply(input vec_t t);
      exp_t e;
      id_valid = t.v;     id_rega = t.ra;      id_usesa = t.ua;
      id_regb = t.rb;     id_usesb = t.ub;     id_writereg = t.wr;
      id_regwrite = t.rw; id_memread = t.mr;   id_syscall = t.sc;
      id_mispredict = t.mp;
      e.ef = t.ef;
      e.en = t.en;
      sb.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t       e;
      logic [4:0] af, an;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected entry queued", tag);
         return;
      end
      e  = sb.pop_front();
      af = {bus_f.FREEZE_IF, bus_f.BUBBLE_ID, bus_f.FLUSH_IF, bus_f.SYS, bus_f.BUSY};
      an = {bus_n.FREEZE_IF, bus_n.BUBBLE_ID, bus_n.FLUSH_IF, bus_n.SYS, bus_n.BUSY};
      checks++;
      if (af !== e.ef) begin
         errors++;
         $display("FAIL %s fwd: got %b expected %b", tag, af, e.ef);
      end
      checks++;
      if (an !== e.en) begin
         errors++;
         $display("FAIL %s nofwd: got %b expected %b", tag, an, e.en);
      end
   endtask

   task automatic step(input vec_t t, input string tag);
      @(posedge CLK);
      #1;
      apply(t);
      @(negedge CLK);
      check(tag);
   endtask

   initial begin
      // load-use: lw $4 ; add $5,$4,$4 ; sub $8,$5,$4
      vecs.push_back(mk(1, 1, 1, 0, 0, 4, 1, 1, 0, 0, O_I, O_I));
      vecs.push_back(mk(1, 4, 1, 4, 1, 5, 1, 0, 0, 0, O_S, O_S));
      vecs.push_back(mk(1, 4, 1, 4, 1, 5, 1, 0, 0, 0, O_I, O_S));
      vecs.push_back(mk(1, 5, 1, 4, 1, 8, 1, 0, 0, 0, O_I, O_S));
      for (int i = 0; i < 3; i++) vecs.push_back(idle_v());
      // addi $3 ; sub $6,$3,$0 held in ID
      vecs.push_back(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0, O_I, O_I));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 3, 1, 0, 1, 6, 1, 0, 0, 0, O_I, O_S));
      vecs.push_back(mk(1, 3, 1, 0, 1, 6, 1, 0, 0, 0, O_I, O_I));
      for (int i = 0; i < 3; i++) vecs.push_back(idle_v());
      // $0 never tracked or matched; unused source ignored
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, O_I, O_I));
      vecs.push_back(mk(1, 0, 1, 0, 1, 10, 1, 0, 0, 0, O_I, O_I));
      vecs.push_back(mk(1, 10, 0, 0, 1, 11, 1, 0, 0, 0, O_I, O_I));
      for (int i = 0; i < 3; i++) vecs.push_back(idle_v());
      // syscall
      vecs.push_back(sys_v(0, O_S)); vecs.push_back(sys_v(0, O_D)); vecs.push_back(sys_v(0, O_D));
      vecs.push_back(sys_v(0, O_X)); vecs.push_back(sys_v(0, O_R)); vecs.push_back(idle_v());
      // LL: same sequence, no SYS
      vecs.push_back(sys_v(1, O_S)); vecs.push_back(sys_v(1, O_D)); vecs.push_back(sys_v(1, O_D));
      vecs.push_back(sys_v(1, O_D)); vecs.push_back(sys_v(1, O_R)); vecs.push_back(idle_v());
      // back-to-back syscalls
      for (int k = 0; k < 2; k++) begin
         vecs.push_back(sys_v(0, O_S)); vecs.push_back(sys_v(0, O_D)); vecs.push_back(sys_v(0, O_D));
         vecs.push_back(sys_v(0, O_X)); vecs.push_back(sys_v(0, O_R));
      end
      vecs.push_back(idle_v());
      // lw $4 ; mispredicted beq $4,$2
      vecs.push_back(mk(1, 1, 1, 0, 0, 4, 1, 1, 0, 0, O_I, O_I));
      vecs.push_back(mk(1, 4, 1, 2, 1, 0, 0, 0, 0, 1, O_S, O_S));
      vecs.push_back(mk(1, 4, 1, 2, 1, 0, 0, 0, 0, 1, O_F, O_S));
      for (int i = 0; i < 3; i++) vecs.push_back(idle_v());

      // reset held with a syscall+mispredict presented: everything low
      RESET = 1'b0;
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_I, O_I));
      #3;
      check("reset_hold");
      apply(idle_v());
      @(negedge CLK);
      check("reset_idle");
      RESET = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // reset in DRAIN with cnt=2, lw $4 still tracked in WB
      step(mk(1, 1, 1, 0, 0, 4, 1, 1, 0, 0, O_I, O_I), "rst_lw");
      step(sys_v(0, O_S), "rst_detect");
      step(sys_v(0, O_D), "rst_drain1");
      step(sys_v(0, O_D), "rst_drain_cnt2");
      #1;
      RESET = 1'b0;
      apply(sys_v(0, O_I));
      #1;
      check("rst_mid_drain");
      #1;
      RESET = 1'b1;
      apply(mk(1, 4, 1, 4, 1, 5, 1, 0, 0, 0, O_I, O_I));
      #1;
      check("rst_fresh_add");
      step(mk(1, 5, 1, 0, 0, 12, 1, 0, 0, 0, O_I, O_S), "rst_add_tracked");
      for (int i = 0; i < 3; i++) step(idle_v(), $sformatf("tail%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
